saved_grid_writer: RTL



---
 rtl/saved_grid_writer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/saved_grid_writer.sv
// Playfield occupancy register: commits locked pieces, clears full rows.
// Optional line scoring enabled by defining LINE_SCORE_EN.
module saved_grid_writer #(
   parameter int COLS     = 10,
   parameter int ROWS     = 24,
   parameter int TOP_ROWS = 2
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 clear_all,
   input  logic                 lock_req,
   input  logic [3:0]           cell_valid,
   input  logic [15:0]          cell_col,
   input  logic [19:0]          cell_row,
   output logic [COLS*ROWS-1:0] savedblocks,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           lines_last,
   output logic [15:0]          lines_total,
   output logic                 game_over,
   output logic [19:0]          score
);

   localparam int N = COLS * ROWS;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SCAN,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_n;

   logic [3:0]  v_q;
   logic [15:0] c_q;
   logic [19:0] r_q;
   logic [4:0]  ptr;
   logic [2:0]  clr_cnt;
   logic [N-1:0] wr_mask;
   logic [N-1:0] shifted;
   logic        overlap;
   logic        row_full;
   logic        top_hit;
   logic        finish;
   logic [16:0] tot_sum;

   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < 4; i++) begin
         if (v_q[i] && int'(c_q[4*i+:4]) < COLS &&
             int'(r_q[5*i+:5]) < ROWS)
            wr_mask[int'(r_q[5*i+:5])*COLS + int'(c_q[4*i+:4])] = 1'b1;
      end
   end

   // Duplicate coordinates collapse in the mask, so only pre-existing bits flag.
   assign overlap  = |(wr_mask & savedblocks);
   assign row_full = &savedblocks[int'(ptr)*COLS +: COLS];
   assign top_hit  = |savedblocks[TOP_ROWS*COLS-1:0];
   assign finish   = (state == SCAN) && !row_full && (ptr == 5'd0);
   assign tot_sum  = {1'b0, lines_total} + 17'(clr_cnt);

   always_comb begin
      shifted = savedblocks;
      for (int r = 0; r < ROWS; r++) begin
         if (r <= int'(ptr)) begin
            if (r == 0)
               shifted[r*COLS +: COLS] = '0;
            else
               shifted[r*COLS +: COLS] = savedblocks[(r-1)*COLS +: COLS];
         end
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (lock_req) state_n = WRITE;
         WRITE:   state_n = SCAN;
         SCAN: begin
            if (row_full)
               state_n = SHIFT;
            else if (ptr == 5'd0)
               state_n = DONE;
         end
         SHIFT:   state_n = SCAN;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (clear_all)
         state_n = IDLE;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Result registers load on the edge entering DONE so they are valid with done.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         savedblocks <= '0;
         lines_last  <= '0;
         lines_total <= '0;
         game_over   <= 1'b0;
         v_q         <= '0;
         c_q         <= '0;
         r_q         <= '0;
         ptr         <= '0;
         clr_cnt     <= '0;
      end else if (clear_all) begin
         savedblocks <= '0;
         lines_last  <= '0;
         lines_total <= '0;
         game_over   <= 1'b0;
         ptr         <= '0;
         clr_cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (lock_req) begin
                  v_q <= cell_valid;
                  c_q <= cell_col;
                  r_q <= cell_row;
               end
            end
            WRITE: begin
               savedblocks <= savedblocks | wr_mask;
               if (overlap)
                  game_over <= 1'b1;
               ptr     <= 5'(ROWS - 1);
               clr_cnt <= '0;
            end
            SCAN: begin
               if (finish) begin
                  lines_last  <= clr_cnt;
                  lines_total <= tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
                  if (top_hit)
                     game_over <= 1'b1;
               end else if (!row_full) begin
                  ptr <= ptr - 5'd1;
               end
            end
            SHIFT: begin
               savedblocks <= shifted;
               clr_cnt     <= clr_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef LINE_SCORE_EN
   logic [19:0] score_q;
   logic [10:0] pts;
   logic [20:0] score_sum;

   always_comb begin
      pts = '0;
      unique case (clr_cnt)
         3'd1:    pts = 11'd40;
         3'd2:    pts = 11'd100;
         3'd3:    pts = 11'd300;
         3'd4:    pts = 11'd1200;
         default: pts = 11'd0;
      endcase
   end

   assign score_sum = {1'b0, score_q} + 21'(pts);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         score_q <= '0;
      else if (clear_all)
         score_q <= '0;
      else if (finish)
         score_q <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
